// File: rtl/onehot_sel_seq.sv
// Registered one-hot select generator with direct-load and prescaled auto-scan
// modes; O, IDX and WRAP all come straight from flops.
module onehot_sel_seq #(
  parameter int SEL_W = 5,
  parameter int OUT_W = 32,
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             ld_i,
  input  logic [SEL_W-1:0] s_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [SEL_W-1:0] last_i,
  output logic [OUT_W-1:0] o_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             wrap_o,
  output logic             err_o
);

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_DIRECT = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [OUT_W-1:0] o_q, o_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             active;
  logic             in_range;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    idx_d  = idx_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    if (en_i) begin
      case (mode_i)
        MODE_OFF: pre_d = '0;
        MODE_DIRECT: begin
          if (ld_i) idx_d = s_i;
          pre_d = '0;
        end
        MODE_SCAN: begin
          if (ld_i) begin
            idx_d = s_i;
            pre_d = '0;
          end else if (pre_q == div_i) begin
            pre_d = '0;
            // An index already past LAST wraps on its first step.
            if (idx_q >= last_i) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + SEL_W'(1);
            end
          end else begin
            pre_d = pre_q + DIV_W'(1);
          end
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  // Decode from the next index so O and IDX change on the same edge.
  always_comb begin
    active   = en_i && (mode_i != MODE_OFF);
    in_range = int'(idx_d) < OUT_W;
    o_d      = '0;
    for (int i = 0; i < OUT_W; i++) begin
      o_d[i] = active && (idx_d == SEL_W'(i));
    end
    err_d = err_q | (active && !in_range);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q  <= '0;
      pre_q  <= '0;
      o_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      o_q    <= o_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign o_o    = o_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_onehot_sel_seq.sv
// Self-checking bench for onehot_sel_seq: directed scenarios plus randomized
// traffic compared against an integer reference model of the select rules.
module tb_onehot_sel_seq;

  localparam int SEL_W = 5;
  localparam int OUT_W = 24;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic             ld;
  logic [SEL_W-1:0] s;
  logic [DIV_W-1:0] div;
  logic [SEL_W-1:0] last;
  logic [OUT_W-1:0] o;
  logic [SEL_W-1:0] idx;
  logic             wrap;
  logic             err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int          m_idx;
  int          m_pre;
  bit          m_err;
  bit          m_wrap;
  logic [31:0] m_o;

  onehot_sel_seq #(.SEL_W(SEL_W), .OUT_W(OUT_W), .DIV_W(DIV_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .mode_i(mode), .ld_i(ld),
    .s_i(s), .div_i(div), .last_i(last),
    .o_o(o), .idx_o(idx), .wrap_o(wrap), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_idx = 0; m_pre = 0; m_err = 0; m_wrap = 0; m_o = 0;
  endtask

  // Apply one rising edge, advance the model on the sampled inputs, then
  // settle 1 time unit so outputs are observed away from the edge.
  task automatic step();
    @(posedge clk);
    m_wrap = 0;
    if (en) begin
      if (mode == 2'd1) begin
        if (ld) m_idx = int'(s);
        m_pre = 0;
      end else if (mode == 2'd0) begin
        m_pre = 0;
      end else if (mode == 2'd2) begin
        if (ld) begin
          m_idx = int'(s); m_pre = 0;
        end else if (m_pre == int'(div)) begin
          m_pre = 0;
          if (m_idx >= int'(last)) begin m_idx = 0; m_wrap = 1; end
          else m_idx = (m_idx + 1) % (1 << SEL_W);
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
    if (en && mode != 2'd0 && m_idx < OUT_W) m_o = 32'd1 << m_idx;
    else m_o = 0;
    if (en && mode != 2'd0 && m_idx >= OUT_W) m_err = 1;
    #1;
  endtask

  task automatic compare_model(input string tag);
    vectors++;
    if (o !== m_o[OUT_W-1:0] || idx !== SEL_W'(m_idx) || wrap !== m_wrap || err !== m_err) begin
      miscompares++;
      $display("FAIL %s: got o=%h idx=%0d wrap=%b err=%b want o=%h idx=%0d wrap=%b err=%b",
               tag, o, idx, wrap, err, m_o[OUT_W-1:0], m_idx, m_wrap, m_err);
    end
  endtask

  task automatic test_reset();
    en = 0; mode = 0; ld = 0; s = 0; div = 0; last = 0;
    rst_n = 0;
    model_reset();
    #12;
    vectors++;
    if (o !== '0 || idx !== '0 || wrap !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got o=%h idx=%0d wrap=%b err=%b want all zero", o, idx, wrap, err);
    end
    rst_n = 1;
    step();
    compare_model("reset_idle");
  endtask

  task automatic test_direct();
    en = 1; mode = 2'd1; ld = 1; s = 5;
    step();
    vectors++;
    if (o !== 24'h000020 || idx !== 5'd5) begin
      miscompares++;
      $display("FAIL direct_load: got o=%h idx=%0d want o=000020 idx=5", o, idx);
    end
    ld = 0; s = 9;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (o !== 24'h000020) begin
        miscompares++;
        $display("FAIL direct_hold: got o=%h want 000020", o);
      end
    end
  endtask

  // Starting at idx=0 with pre=0, cycle k after entering SCAN shows index
  // (k/(DIV+1)) mod (LAST+1), and WRAP fires whenever k is a full period.
  task automatic test_scan();
    int exp_i;
    bit exp_w;
    mode = 2'd1; ld = 1; s = 0;
    step();
    mode = 2'd2; ld = 0; div = 2; last = 3;
    for (int k = 1; k <= 26; k++) begin
      step();
      exp_i = (k / 3) % 4;
      exp_w = (k % 12) == 0;
      vectors++;
      if (o !== (24'd1 << exp_i) || wrap !== exp_w) begin
        miscompares++;
        $display("FAIL scan k=%0d: got o=%h wrap=%b want o=%h wrap=%b",
                 k, o, wrap, 24'd1 << exp_i, exp_w);
      end
    end
  endtask

  task automatic test_load_mid_scan();
    ld = 1; s = 2;
    step();
    vectors++;
    if (o !== 24'h4 || idx !== 5'd2) begin
      miscompares++;
      $display("FAIL scan_load: got o=%h idx=%0d want o=000004 idx=2", o, idx);
    end
    ld = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (o !== 24'h4) begin
        miscompares++;
        $display("FAIL scan_load_dwell: got o=%h want 000004", o);
      end
    end
    step();
    vectors++;
    if (o !== 24'h8) begin
      miscompares++;
      $display("FAIL scan_load_step: got o=%h want 000008", o);
    end
    en = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (o !== '0 || idx !== 5'd3 || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL en_off: got o=%h idx=%0d wrap=%b want o=0 idx=3 wrap=0", o, idx, wrap);
      end
    end
    en = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      compare_model("en_resume");
    end
  endtask

  task automatic test_hold();
    logic [OUT_W-1:0] held;
    div = 4; last = 7;
    for (int k = 0; k < 7; k++) step();
    held = o;
    mode = 2'd3;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (o !== held || o !== m_o[OUT_W-1:0]) begin
        miscompares++;
        $display("FAIL hold: got o=%h want %h", o, m_o[OUT_W-1:0]);
      end
    end
    mode = 2'd2;
    for (int k = 0; k < 12; k++) begin
      step();
      compare_model("hold_resume");
    end
  endtask

  task automatic test_err();
    mode = 2'd1; ld = 1; s = 30;
    step();
    vectors++;
    if (o !== '0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set: got o=%h err=%b want o=0 err=1", o, err);
    end
    s = 1;
    step();
    vectors++;
    if (o !== 24'h2 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got o=%h err=%b want o=000002 err=1", o, err);
    end
    ld = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 5) < 3) ? 2'd2 : 2'($urandom_range(0, 3));
      ld   = ($urandom_range(0, 11) == 0);
      s    = 5'($urandom_range(0, 31));
      div  = 8'($urandom_range(0, 3));
      last = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      step();
      compare_model("random");
    end
  endtask

  task automatic test_async_reset();
    en = 1; mode = 2'd2; ld = 0; div = 0; last = 5;
    for (int k = 0; k < 4; k++) step();
    #3;
    rst_n = 0;
    model_reset();
    #1;
    vectors++;
    if (o !== '0 || idx !== '0 || wrap !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got o=%h idx=%0d wrap=%b err=%b want all zero", o, idx, wrap, err);
    end
    div = 2; last = 3;
    #2;
    rst_n = 1;
    step();
    vectors++;
    if (o !== 24'h1 || idx !== 5'd0) begin
      miscompares++;
      $display("FAIL post_reset_scan: got o=%h idx=%0d want o=000001 idx=0", o, idx);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      compare_model("post_reset");
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_load_mid_scan();
    test_hold();
    test_err();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
